// File: rtl/nmi_event_source.sv
// nmi_event_source
//
// Upstream event generator for the NMI / config-ROM paging logic. Five raw
// request lines are synchronised and debounced. Their rising edges are latched
// as pending requests. The requests are then presented one at a time, lowest
// index first, on a one-hot event bus. The bus handshakes against the paging
// block's active flag, so no request is lost or merged into a running NMI
// session.
//
// Ports:
//   clk                    system clock
//   rst_n                  synchronous, active-low reset
//   raw_req[4:0]           asynchronous level requests, bit i = event i
//   enable                 event generation enable (config register bit)
//   page_configrom_active  busy/ack from the NMI paging block
//   userevents[4:0]        one-hot event presented to the NMI block, 0 = none
//   pending[4:0]           latched requests not yet issued
//   busy                   handshake FSM is not idle
//   dropped                sticky: an issued event timed out unacknowledged

module nmi_event_source #(
    parameter int unsigned         CNT_W       = 16,
    parameter logic [CNT_W-1:0]    DEBOUNCE    = 16'd50000,
    parameter logic [CNT_W-1:0]    ACK_TIMEOUT = 16'd1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] raw_req,
    input  logic       enable,
    input  logic       page_configrom_active,
    output logic [4:0] userevents,
    output logic [4:0] pending,
    output logic       busy,
    output logic       dropped
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DB_LAST = DEBOUNCE - CNT_ONE;
    localparam logic [CNT_W-1:0] TO_LAST = ACK_TIMEOUT - CNT_ONE;

    logic [4:0]       sync1;
    logic [4:0]       sync2;
    logic [4:0]       db;
    logic [4:0]       db_q;
    logic [CNT_W-1:0] db_cnt [5];
    logic [4:0]       rise;
    logic [4:0]       lowest;
    logic [4:0]       clear_mask;

    state_t           state;
    state_t           state_next;
    logic [4:0]       events_next;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_next;
    logic             dropped_next;

    // Two-flop synchroniser feeding a per-bit debouncer. While the synchronised
    // input disagrees with the debounced state, a counter runs. The debounced bit
    // flips only after DEBOUNCE consecutive disagreeing cycles. Any agreeing
    // cycle restarts the count, so short glitches never reach db.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_q  <= '0;
            for (int i = 0; i < 5; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw_req;
            sync2 <= sync1;
            db_q  <= db;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] != db[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db[i]     <= ~db[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CNT_ONE;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Only 0->1 transitions of the debounced state count as requests.
    // x & -x isolates the lowest set bit, which gives the issue priority.
    assign rise   = db & ~db_q;
    assign lowest = pending & (~pending + 5'd1);

    // Pending requests accumulate in every FSM state. The bit being issued
    // is cleared, but a rising edge in the same cycle sets it again, so a new
    // request is never swallowed. With generation disabled, nothing is kept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (!enable) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clear_mask) | rise;
        end
    end

    // Handshake FSM state register. The event bus, the ack timer and the sticky
    // drop flag are registered together with the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            userevents <= '0;
            timer      <= '0;
            dropped    <= 1'b0;
        end else begin
            state      <= state_next;
            userevents <= events_next;
            timer      <= timer_next;
            dropped    <= dropped_next;
        end
    end

    // Next-state logic:
    // - IDLE: issues the lowest pending request, but only when the paging
    //   block is quiet.
    // - ISSUE: holds the event until the paging block acknowledges it, or
    //   until the timer expires. An expired event is discarded and flagged.
    // - WAIT_DONE: waits for the session to end before the next event may go
    //   out.
    always_comb begin
        state_next   = state;
        events_next  = userevents;
        timer_next   = timer;
        dropped_next = dropped;
        clear_mask   = '0;
        case (state)
            IDLE: begin
                if ((pending != '0) && enable && !page_configrom_active) begin
                    events_next = lowest;
                    clear_mask  = lowest;
                    timer_next  = TO_LAST;
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                if (page_configrom_active) begin
                    events_next = '0;
                    state_next  = WAIT_DONE;
                end else if (timer == '0) begin
                    events_next  = '0;
                    dropped_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    timer_next = timer - CNT_ONE;
                end
            end
            WAIT_DONE: begin
                if (!page_configrom_active) begin
                    state_next = IDLE;
                end
            end
            default: begin
                events_next = '0;
                state_next  = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_nmi_event_source.sv
// tb_nmi_event_source
//
// Bench for nmi_event_source with DEBOUNCE=4 and ACK_TIMEOUT=8. Each
// scenario task drives raw requests and pushes the event it expects onto a
// queue. When the DUT raises userevents, the task pops the queue and compares.
// A simple behavioural NMI block raises and drops page_configrom_active around
// each event.

module tb_nmi_event_source;

    logic       clk;
    logic       rst_n;
    logic [4:0] raw_req;
    logic       enable;
    logic       page_configrom_active;
    logic [4:0] userevents;
    logic [4:0] pending;
    logic       busy;
    logic       dropped;

    int total;
    int bad;
    logic [4:0] exp_q [$];

    nmi_event_source #(
        .CNT_W(16),
        .DEBOUNCE(16'd4),
        .ACK_TIMEOUT(16'd8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .raw_req(raw_req),
        .enable(enable),
        .page_configrom_active(page_configrom_active),
        .userevents(userevents),
        .pending(pending),
        .busy(busy),
        .dropped(dropped)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a scenario wedges outside its own cycle budgets.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] pop_exp();
        if (exp_q.size() == 0) return 5'bxxxxx;
        return exp_q.pop_front();
    endfunction

    task automatic wait_event(input int budget, output logic [4:0] ev, output int n);
        n  = 0;
        ev = userevents;
        while (ev == 5'b0 && n < budget) begin
            tick();
            n++;
            ev = userevents;
        end
    endtask

    task automatic nmi_session(input int len);
        tick();
        page_configrom_active = 1'b1;
        repeat (len) tick();
        page_configrom_active = 1'b0;
        tick();
    endtask

    task automatic settle();
        raw_req = 5'b0;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total++;
        if ({userevents, pending, busy, dropped} !== 12'b0)
            $display("[TB] FAIL reset_outputs: got %b, expected all zero",
                     {userevents, pending, busy, dropped});
        if ({userevents, pending, busy, dropped} !== 12'b0) bad++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_event();
        logic [4:0] ev;
        logic [4:0] exp;
        int n;
        raw_req = 5'b00100;
        exp_q.push_back(5'b00100);
        wait_event(20, ev, n);
        exp = pop_exp();
        total++;
        if (ev !== exp) begin
            bad++;
            $display("[TB] FAIL single_event: got %b, expected %b", ev, exp);
        end
        total++;
        if (n !== 8) begin
            bad++;
            $display("[TB] FAIL single_latency: got %0d cycles, expected 8", n);
        end
        tick();
        page_configrom_active = 1'b1;
        total++;
        if (userevents !== exp) begin
            bad++;
            $display("[TB] FAIL single_hold: got %b, expected %b", userevents, exp);
        end
        tick();
        total++;
        if (userevents !== 5'b0 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_clear: got ev=%b busy=%b, expected ev=00000 busy=1",
                     userevents, busy);
        end
        repeat (19) tick();
        page_configrom_active = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || pending !== 5'b0) begin
            bad++;
            $display("[TB] FAIL single_done: got busy=%b pending=%b, expected busy=0 pending=00000",
                     busy, pending);
        end
        settle();
    endtask

    task automatic test_glitch();
        logic seen;
        seen = 1'b0;
        raw_req[0] = 1'b1;
        repeat (3) tick();
        raw_req[0] = 1'b0;
        repeat (15) begin
            tick();
            if (dut.db !== 5'b0 || pending !== 5'b0 || userevents !== 5'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("[TB] FAIL glitch: got activity=%b, expected activity=0", seen);
        end
    endtask

    task automatic test_priority();
        logic [4:0] ev;
        logic [4:0] exp;
        int n;
        raw_req = 5'b10010;
        exp_q.push_back(5'b00010);
        exp_q.push_back(5'b10000);
        wait_event(20, ev, n);
        exp = pop_exp();
        total++;
        if (ev !== exp) begin
            bad++;
            $display("[TB] FAIL prio_first: got %b, expected %b", ev, exp);
        end
        total++;
        if (pending !== 5'b10000) begin
            bad++;
            $display("[TB] FAIL prio_pending: got %b, expected 10000", pending);
        end
        nmi_session(6);
        wait_event(10, ev, n);
        exp = pop_exp();
        total++;
        if (ev !== exp) begin
            bad++;
            $display("[TB] FAIL prio_second: got %b, expected %b", ev, exp);
        end
        nmi_session(6);
        settle();
    endtask

    task automatic test_busy_accumulation();
        logic [4:0] ev;
        logic [4:0] exp;
        int n;
        logic extra;
        raw_req = 5'b00001;
        exp_q.push_back(5'b00001);
        wait_event(20, ev, n);
        exp = pop_exp();
        total++;
        if (ev !== exp) begin
            bad++;
            $display("[TB] FAIL acc_first: got %b, expected %b", ev, exp);
        end
        raw_req = 5'b0;
        tick();
        page_configrom_active = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            raw_req[3] = 1'b1;
            repeat (8) tick();
            raw_req[3] = 1'b0;
            repeat (8) tick();
        end
        total++;
        if (pending !== 5'b01000 || userevents !== 5'b0 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL acc_pending: got pending=%b ev=%b busy=%b, expected 01000 00000 1",
                     pending, userevents, busy);
        end
        exp_q.push_back(5'b01000);
        page_configrom_active = 1'b0;
        wait_event(20, ev, n);
        exp = pop_exp();
        total++;
        if (ev !== exp) begin
            bad++;
            $display("[TB] FAIL acc_event: got %b, expected %b", ev, exp);
        end
        total++;
        if (n !== 2) begin
            bad++;
            $display("[TB] FAIL acc_gap: got %0d cycles, expected 2", n);
        end
        nmi_session(4);
        extra = 1'b0;
        repeat (20) begin
            tick();
            if (userevents !== 5'b0 || pending !== 5'b0) extra = 1'b1;
        end
        total++;
        if (extra !== 1'b0) begin
            bad++;
            $display("[TB] FAIL acc_single: got extra_event=%b, expected 0", extra);
        end
    endtask

    task automatic test_timeout();
        logic [4:0] ev;
        logic [4:0] exp;
        int n;
        int hi;
        raw_req = 5'b00001;
        exp_q.push_back(5'b00001);
        wait_event(20, ev, n);
        exp = pop_exp();
        total++;
        if (ev !== exp) begin
            bad++;
            $display("[TB] FAIL to_event: got %b, expected %b", ev, exp);
        end
        hi = 1;
        while (userevents !== 5'b0 && hi < 30) begin
            tick();
            if (userevents !== 5'b0) hi++;
        end
        total++;
        if (hi !== 8) begin
            bad++;
            $display("[TB] FAIL to_length: got %0d cycles, expected 8", hi);
        end
        total++;
        if (dropped !== 1'b1 || busy !== 1'b0 || pending !== 5'b0) begin
            bad++;
            $display("[TB] FAIL to_state: got dropped=%b busy=%b pending=%b, expected 1 0 00000",
                     dropped, busy, pending);
        end
        raw_req = 5'b00101;
        exp_q.push_back(5'b00100);
        wait_event(20, ev, n);
        exp = pop_exp();
        total++;
        if (ev !== exp) begin
            bad++;
            $display("[TB] FAIL to_next: got %b, expected %b", ev, exp);
        end
        nmi_session(4);
        total++;
        if (dropped !== 1'b1) begin
            bad++;
            $display("[TB] FAIL to_sticky: got %b, expected 1", dropped);
        end
        settle();
    endtask

    task automatic test_enable();
        logic seen;
        seen = 1'b0;
        enable = 1'b0;
        raw_req = 5'b00010;
        repeat (15) begin
            tick();
            if (pending !== 5'b0 || userevents !== 5'b0) seen = 1'b1;
        end
        enable = 1'b1;
        repeat (10) begin
            tick();
            if (pending !== 5'b0 || userevents !== 5'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("[TB] FAIL enable_block: got activity=%b, expected activity=0", seen);
        end
        settle();
    endtask

    task automatic test_reset_mid();
        logic [4:0] ev;
        logic [4:0] exp;
        int n;
        raw_req = 5'b01000;
        exp_q.push_back(5'b01000);
        wait_event(20, ev, n);
        exp = pop_exp();
        total++;
        if (ev !== exp) begin
            bad++;
            $display("[TB] FAIL rst_event: got %b, expected %b", ev, exp);
        end
        tick();
        rst_n = 1'b0;
        tick();
        total++;
        if ({userevents, pending, busy, dropped} !== 12'b0) begin
            bad++;
            $display("[TB] FAIL rst_abort: got %b, expected all zero",
                     {userevents, pending, busy, dropped});
        end
        rst_n = 1'b1;
        exp_q.push_back(5'b01000);
        wait_event(20, ev, n);
        exp = pop_exp();
        total++;
        if (ev !== exp || n !== 8) begin
            bad++;
            $display("[TB] FAIL rst_refire: got %b after %0d cycles, expected %b after 8",
                     ev, n, exp);
        end
        nmi_session(4);
        settle();
    endtask

    // Scenario sequence
    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        raw_req = 5'b0;
        enable = 1'b1;
        page_configrom_active = 1'b0;
        test_reset();
        test_single_event();
        test_glitch();
        test_priority();
        test_busy_accumulation();
        test_timeout();
        test_enable();
        test_reset_mid();
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nmi_event_source.md
# nmi_event_source

Upstream event generator for the NMI/config-ROM paging logic. It synchronises and debounces five raw user-request lines, such as hotkey flags from the keyboard decoder and the physical NMI button. It latches their rising edges as pending requests and presents them one at a time on `userevents`, handshaking against `page_configrom_active` so that no request is lost or merged into an in-flight NMI session.

## Interface
Parameters:
- `CNT_W`, 16, width of each debounce counter and of the ack-timeout counter.
- `DEBOUNCE`, 16'd50000, consecutive stable cycles required before a debounced bit changes (≥1).
- `ACK_TIMEOUT`, 16'd1024, cycles to wait for `page_configrom_active` to rise after issuing an event (≥2).

Ports:
- `clk`, input, 1, system clock.
- `rst_n`, input, 1, reset: synchronous, active-low.
- `raw_req`, input, 5, asynchronous level requests, bit i = event i.
- `enable`, input, 1, event generation enable (config register bit).
- `page_configrom_active`, input, 1, busy/ack from the NMI paging block.
- `userevents`, output, 5, one-hot event presented to the NMI block; 0 = none.
- `pending`, output, 5, latched requests not yet issued.
- `busy`, output, 1, FSM not in IDLE.
- `dropped`, output, 1, sticky: an issued event timed out unacknowledged.

## Operation
- Sync: 2-FF synchroniser per `raw_req` bit.
- Debounce: per bit, the debounced state `db[i]` is compared to the sync output. On a mismatch, the bit counter increments. On a match, the counter clears. When the counter reaches `DEBOUNCE`-1 on a mismatch, `db[i]` flips and the counter clears.
- Edge: a 0→1 transition of `db[i]` sets `pending[i]`, provided `enable`=1. Further edges on a bit already pending merge into it. Falling edges are ignored.
- `enable`=0: clears `pending` every cycle and blocks IDLE→ISSUE. Any in-flight sequence completes normally.
- FSM states:
  - IDLE:
    - If `pending`≠0, `enable`=1 and `page_configrom_active`=0:
      - Select the lowest set index i.
      - Register `userevents` to one-hot(i).
      - Clear `pending[i]`; if `pending[i]` would be re-set that same cycle, the set wins.
      - Load the timeout counter, then go to ISSUE.
    - If `page_configrom_active`=1 (session started elsewhere), stay in IDLE.
  - ISSUE:
    - Hold `userevents`.
    - If `page_configrom_active`=1: set `userevents` to 0 and go to WAIT_DONE.
    - Otherwise, when `ACK_TIMEOUT` cycles elapse: set `userevents` to 0, set `dropped`, and go to IDLE. The event is discarded, not re-pended.
  - WAIT_DONE: when `page_configrom_active`=0, go to IDLE.
- Requests arriving in any state accumulate in `pending`. They are issued in ascending index order, one per NMI session.
- `busy` = (state≠IDLE). `dropped` clears only on reset.

## Timing
- Reset values:
  - `userevents`=0, `pending`=0, `busy`=0, `dropped`=0, FSM=IDLE.
  - All `db`, synchroniser flops and counters = 0.
- A request line held high through reset is treated as a new rising edge. It fires once after debounce.
- Latency, for `raw_req[i]` rising and stable with FSM idle: `userevents` becomes nonzero DEBOUNCE+4 cycles after the first clk edge sampling it high.
  - 2 cycles synchroniser.
  - DEBOUNCE cycles to `db`.
  - 1 cycle pending.
  - 1 cycle registered issue.
- Glitches shorter than DEBOUNCE sync cycles produce no event.
- `userevents` remains at most one-hot and stays constant for its whole nonzero period.
- `userevents` is asserted only while `page_configrom_active` was 0 when issued. It deasserts the cycle after `page_configrom_active` is seen high.
- Minimum gap between successive events: the NMI session length plus 1 cycle, which is the WAIT_DONE→IDLE→ISSUE path.
- Reset mid-operation aborts any state immediately to the reset values. The next cycle behaves as after power-up.

## Test plan
- Single event:
  - Stimulus: DEBOUNCE=4; raise `raw_req`=5'b00100 and hold; model the NMI block raising `active` 1 cycle after sampling and dropping it 20 cycles later.
  - Required response: `userevents`=5'b00100 exactly 8 cycles after the raise, cleared the cycle after `active`=1, `busy` low 1 cycle after `active` falls, `pending`=0.
- Glitch rejection:
  - Stimulus: 3-cycle pulse on `raw_req[0]` with DEBOUNCE=4.
  - Required response: `db`, `pending` and `userevents` stay 0.
- Priority and queuing:
  - Stimulus: `raw_req`=5'b10010 rising together.
  - Required response: first session has `userevents`=5'b00010 and `pending`=5'b10000 during it; a second session follows with 5'b10000.
- Busy accumulation:
  - Stimulus: during WAIT_DONE, pulse `raw_req[3]` twice, each longer than DEBOUNCE.
  - Required response: `pending[3]`=1 and exactly one event 5'b01000 after `active` falls.
- Timeout:
  - Stimulus: ACK_TIMEOUT=8; `active` never rises.
  - Required response: `userevents` nonzero for 8 cycles then 0, `dropped`=1 sticky, FSM back in IDLE, the next event still issued.
- Enable and reset:
  - Stimulus: `enable`=0 while a request debounces high.
  - Required response: no pending bit and no event.
  - Stimulus: assert `rst_n`=0 during ISSUE.
  - Required response: all outputs 0 the next cycle.
